dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, is the number of bus wait cycles before an access is aborted (range 2..255).
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF, is the read data returned on an aborted or misaligned load.
REQ-003 Port clk, input, 1 bit, is the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit, is the reset: asynchronous, active-low.
REQ-005 Port mem_valid, input, 1 bit, means the MEM-stage instruction is valid.
REQ-006 Port mem_ren, input, 1 bit, is the MEM-stage load request.
REQ-007 Port mem_wen, input, 1 bit, is the MEM-stage store request.
REQ-008 Port mem_addr, input, 32 bits, is the byte address.
REQ-009 Port mem_dout, input, 32 bits, is the store data.
REQ-010 Port mem_din, output, 32 bits, is the load data returned to the datapath.
REQ-011 Port mem_stall, output, 1 bit, freezes IF/ID/EXE/MEM enables and holds WB reset while high.
REQ-012 Port bus_req, output, 1 bit, is the bus request, held until acknowledged.
REQ-013 Port bus_we, output, 1 bit, is the bus write strobe, valid with bus_req.
REQ-014 Port bus_addr, output, 30 bits, is the word address, mem_addr[31:2].
REQ-015 Port bus_wdata, output, 32 bits, is the bus write data.
REQ-016 Port bus_rdata, input, 32 bits, is the bus read data, valid with bus_ack.
REQ-017 Port bus_ack, input, 1 bit, is a single-cycle bus completion pulse.
REQ-018 Port err, output, 1 bit, is a sticky fault flag.
REQ-019 Port err_code, output, 2 bits, holds 1 = misaligned, 2 = timeout, 3 = ren and wen both set.

Function
REQ-020 States: IDLE, REQ, DONE. Encoding comes from the shared package.
REQ-021 An access is acc = mem_valid & (mem_ren | mem_wen).
- mem_stall = acc & (state != DONE), combinational, so it is high in the same cycle the access appears.
REQ-022 IDLE with acc and mem_addr[1:0]==0:
- Latch addr, wdata and we (we = mem_wen).
- Go to REQ and assert bus_req from the next cycle.
REQ-023 IDLE with acc and mem_addr[1:0]!=0:
- No bus access.
- Go to DONE with err=1, err_code=1; a load returns ERR_DATA.
REQ-024 REQ: bus_req=1 and the latched bus_addr, bus_we and bus_wdata stay stable until bus_ack.
- On bus_ack: capture bus_rdata (loads only) and go to DONE.
REQ-025 Watchdog counts cycles spent in REQ.
- When the count reaches TIMEOUT with no ack: drop bus_req, go to DONE, err=1, err_code=2, load data = ERR_DATA.
- A bus_ack arriving in the same cycle as expiry wins: the access completes normally.
REQ-026 DONE: mem_stall=0 and mem_din holds the captured data; unconditionally return to IDLE next cycle.
- This guarantees one access per instruction; a back-to-back access is accepted from IDLE on the following cycle.
REQ-027 mem_ren & mem_wen together: treat as a store and set err=1, err_code=3.
REQ-028 Unloaded latency: acc cycle (IDLE), then REQ for at least 1 cycle, then DONE.
- Minimum stall is 2 cycles when the ack arrives in the first REQ cycle.
REQ-029 In IDLE, mem_din = bus_rdata register.
- bus_ack seen outside REQ is ignored.
- mem_valid dropping during REQ does not cancel the bus transaction.
REQ-030 err and err_code are sticky: only reset clears them, and the first fault's code is kept.

Reset
REQ-031 When rst_n is low, regardless of clk:
- state=IDLE, watchdog=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
- Data register=0, err=0, err_code=0.
REQ-032 Reset during REQ abandons the transaction.
- bus_req is low immediately.
- A late bus_ack after reset release is ignored in IDLE.
REQ-033 Once rst_n rises, mem_stall depends only on acc and state.

Structure
REQ-034 State encoding, err_code values and bus width constants go in shared package mips_mem_pkg.
REQ-035 The watchdog is a sub-module, wdt_counter (clear, enable, expired), parameterized by TIMEOUT.
REQ-036 Target size: 120–400 lines of RTL.

Verification
REQ-037 Load, addr 0x10, bus_ack on the first REQ cycle with rdata 0x12345678:
- stall for 2 cycles, mem_din=0x12345678 in DONE, bus_we=0.
REQ-038 Store, addr 0x20, data 0xCAFEF00D, ack after 5 cycles:
- bus_req held for 5 cycles with addr 0x8 and wdata stable; stall for 6 cycles.
REQ-039 Load, addr 0x13:
- no bus_req; err=1, err_code=1, mem_din=0xDEADBEEF; stall for 1 cycle.
REQ-040 Load with no ack, TIMEOUT=4:
- bus_req high for 4 cycles, then DONE with err_code=2.
- Second scenario: ack on the 4th cycle gives normal completion and err stays 0.
REQ-041 Pull rst_n low mid-REQ:
- bus_req drops in the same cycle; state is IDLE after release; a stray bus_ack causes no transition.
REQ-042 Two back-to-back loads, immediate acks:
- each is issued exactly once; mem_stall pattern 1,1,0,1,1,0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding, fault codes and bus widths.
package mips_mem_pkg;

    localparam int unsigned BusAw = 30;
    localparam int unsigned BusDw = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [1:0] ErrNone     = 2'd0;
    localparam logic [1:0] ErrMisalign = 2'd1;
    localparam logic [1:0] ErrTimeout  = 2'd2;
    localparam logic [1:0] ErrRdWr     = 2'd3;

endpackage

// File: rtl/wdt_counter.sv
// Bus watchdog: counts enabled cycles and flags expiry on the TIMEOUT-th enabled cycle.
module wdt_counter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Combinational so the controller can leave REQ in the same cycle the limit is hit.
    assign o_expired = i_enable && (r_count == LastCount);

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: one bus access per instruction, with watchdog and sticky faults.
module dmem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    input  logic             mem_ren,
    input  logic             mem_wen,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_dout,
    output logic [31:0]      mem_din,
    output logic             mem_stall,
    output logic             bus_req,
    output logic             bus_we,
    output logic [BusAw-1:0] bus_addr,
    output logic [BusDw-1:0] bus_wdata,
    input  logic [BusDw-1:0] bus_rdata,
    input  logic             bus_ack,
    output logic             err,
    output logic [1:0]       err_code
);

    state_e           r_state;
    state_e           w_state_d;
    logic [BusAw-1:0] r_addr;
    logic [BusDw-1:0] r_wdata;
    logic             r_we;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [1:0]       r_err_code;

    logic             w_acc;
    logic             w_aligned;
    logic             w_accept;
    logic             w_expired;
    logic             w_in_req;
    logic             w_fault;
    logic [1:0]       w_fault_code;
    logic             w_rdata_en;
    logic [31:0]      w_rdata_d;

    assign w_acc     = mem_valid && (mem_ren || mem_wen);
    assign w_aligned = (mem_addr[1:0] == 2'b00);
    assign w_in_req  = (r_state == StReq);
    assign w_accept  = (r_state == StIdle) && w_acc && w_aligned;

    wdt_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (!w_in_req),
        .i_enable  (w_in_req),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_fault      = 1'b0;
        w_fault_code = ErrNone;
        w_rdata_en   = 1'b0;
        w_rdata_d    = r_rdata;
        unique case (r_state)
            StIdle: begin
                if (w_acc) begin
                    if (!w_aligned) begin
                        w_state_d    = StDone;
                        w_fault      = 1'b1;
                        w_fault_code = ErrMisalign;
                        // A misaligned read+write is treated as a store, so no data update.
                        if (!mem_wen) begin
                            w_rdata_en = 1'b1;
                            w_rdata_d  = ERR_DATA;
                        end
                    end else begin
                        w_state_d = StReq;
                        if (mem_ren && mem_wen) begin
                            w_fault      = 1'b1;
                            w_fault_code = ErrRdWr;
                        end
                    end
                end
            end
            StReq: begin
                // An ack in the expiry cycle still completes the access normally.
                if (bus_ack) begin
                    w_state_d  = StDone;
                    w_rdata_en = !r_we;
                    w_rdata_d  = bus_rdata;
                end else if (w_expired) begin
                    w_state_d    = StDone;
                    w_fault      = 1'b1;
                    w_fault_code = ErrTimeout;
                    w_rdata_en   = !r_we;
                    w_rdata_d    = ERR_DATA;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_err_code <= ErrNone;
        end else begin
            if (w_accept) begin
                r_addr  <= mem_addr[31:2];
                r_wdata <= mem_dout;
                r_we    <= mem_wen;
            end
            if (w_rdata_en) begin
                r_rdata <= w_rdata_d;
            end
            if (w_fault && !r_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_fault_code;
            end
        end
    end

    assign mem_stall = w_acc && (r_state != StDone);
    assign mem_din   = r_rdata;
    assign bus_req   = w_in_req;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule
